branch_redirect_ctrl: RTL
=========================

Name: branch_redirect_ctrl

Overview:
- Sequences control-flow redirects produced by the EX-stage branch unit and the trap unit.
- On a taken branch/jump or a trap, flushes IF/ID and discards stale in-flight instruction-bus responses. Then holds a redirect request to the fetch unit until accepted.
- Routes branch-target misalignment to the trap unit as a one-cycle exception pulse.
- Sits between the EX stage, the trap/CSR unit and the IFU.

Parameters:
- CNT_W, 2, width of the outstanding-fetch counters (maximum 2^CNT_W-1 in-flight requests).
- WAIT_DRAIN, 1, 1 = present redirect only after all stale responses have been dropped; 0 = present redirect immediately.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- ex_valid  in  1  EX holds a valid instruction
- ex_stall  in  1  EX is held this cycle; the branch result is not consumed
- take_branch  in  1  branch unit taken indication
- target_pc  in  32  branch unit target, bit0 already 0
- exc_addr_misaligned  in  1  branch unit target misaligned
- trap_req  in  1  trap unit requests a redirect; has priority over branches
- trap_pc  in  32  trap/mret target
- if_outstanding_cnt  in  CNT_W  fetch requests issued and not yet responded, including any response arriving this cycle
- if_rsp_valid  in  1  instruction-bus response this cycle
- flush_if  out  1  kill IF-stage instruction
- flush_id  out  1  kill ID-stage instruction
- drop_rsp  out  1  IFU must discard the response this cycle
- redirect_valid  out  1  redirect request to IFU
- redirect_pc  out  32  redirect address, stable while redirect_valid=1
- redirect_ready  in  1  IFU accepts the redirect
- branch_exc  out  1  one-cycle misaligned-target exception to trap unit
- branch_exc_tval  out  32  faulting target_pc, valid with branch_exc
- busy  out  1  state != IDLE; IFU must not issue new fetches while busy=1

Behaviour:
- Interface: one clock, clk. rst is synchronous, active-high.
- Reset values: state=IDLE, drop_cnt=0, redirect_valid=0, redirect_pc=0, branch_exc=0, branch_exc_tval=0, busy=0. The flush outputs are combinational and therefore 0 in IDLE with no event.
- Events (combinational, evaluated every cycle):
  - br_ev = ex_valid & ~ex_stall & take_branch & ~exc_addr_misaligned.
  - mis_ev = ex_valid & ~ex_stall & take_branch & exc_addr_misaligned.
  - tr_ev = trap_req.
  - The accepted event is tr_ev if set, else br_ev.
- Accept rules:
  - br_ev is accepted only in IDLE; in any other state it is ignored.
  - tr_ev is accepted in every state.
- On an accepted event (cycle T):
  - flush_if=flush_id=1 in cycle T (combinational).
  - drop_rsp=1 in T if if_rsp_valid.
  - drop_cnt <= if_outstanding_cnt - if_rsp_valid.
  - redirect_pc <= trap_pc if tr_ev, else target_pc.
  - Next state: DRAIN if WAIT_DRAIN=1 and the loaded drop_cnt != 0; otherwise REDIRECT.
- mis_ev in IDLE, not masked by tr_ev:
  - branch_exc=1 and branch_exc_tval=target_pc, registered, so visible in T+1 for exactly one cycle.
  - No flush and no redirect; the trap unit follows with trap_req.
- DRAIN:
  - drop_rsp = if_rsp_valid & (drop_cnt != 0).
  - drop_cnt decrements on each dropped response.
  - Go to REDIRECT in the cycle after drop_cnt reaches 0.
- REDIRECT:
  - redirect_valid=1 (registered); redirect_pc held stable.
  - On redirect_valid & redirect_ready, go to IDLE; redirect_valid falls the next cycle.
  - With WAIT_DRAIN=0, drop_cnt keeps draining in parallel, with drop_rsp as in DRAIN, including in IDLE after acceptance.
- tr_ev in DRAIN/REDIRECT:
  - Overrides redirect_pc with trap_pc.
  - Re-asserts flush_if/flush_id.
  - Reloads drop_cnt per the accept rule.
  - Re-enters DRAIN/REDIRECT.
  - A concurrent redirect_ready in the same cycle is ignored, so the old pc is not consumed.
- drop_cnt never underflows; if_rsp_valid with drop_cnt=0 passes through (drop_rsp=0).
- rst mid-operation returns to the reset values in the next cycle; pending redirect and drop state are discarded.

Decomposition:
- Shared package/header:
  - State encoding (IDLE=2'd0, DRAIN=2'd1, REDIRECT=2'd2).
  - Redirect-cause constants (CAUSE_BR, CAUSE_TRAP).
  - Reuse the existing PC/DATA range macros.
- One sub-module, `fetch_drop_counter`: load/decrement/zero-flag for drop_cnt. It is reusable by the IFU for other flush sources.

Test Plan:
- IDLE, br_ev with target_pc=0x0000_0104, if_outstanding_cnt=0, redirect_ready=1 -> flush_if/flush_id=1 in T; redirect_valid=1 with pc 0x104 in T+1; IDLE in T+2.
- br_ev with if_outstanding_cnt=2, if_rsp_valid=0, WAIT_DRAIN=1, then responses in T+2 and T+4 -> drop_rsp=1 on both; redirect_valid first asserted in T+5.
- mis_ev with target_pc=0x0000_0106 -> branch_exc=1 and tval=0x106 in T+1 only; no flush; redirect_valid stays 0.
- REDIRECT with redirect_ready=0, then trap_req with trap_pc=0x8000_0000 together with redirect_ready=1 -> flush re-asserted; redirect_pc becomes 0x8000_0000; the old pc is never accepted.
- br_ev and trap_req in the same cycle (target 0x200, trap 0x80) -> redirect_pc=0x80; a br_ev arriving while busy is ignored.
- rst asserted in DRAIN with drop_cnt=3 -> next cycle: IDLE, drop_cnt=0, redirect_valid=0, drop_rsp=0 on the following response.

Source files
------------

// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared types for the branch/trap redirect controller: FSM states, redirect causes, PC width.
package branch_redirect_ctrl_pkg;

  localparam int PC_W   = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  typedef enum logic {
    CAUSE_BR   = 1'b0,
    CAUSE_TRAP = 1'b1
  } cause_t;

  function automatic logic [PC_W-1:0] sel_redirect_pc(cause_t cause,
                                                      logic [PC_W-1:0] br_pc,
                                                      logic [PC_W-1:0] tr_pc);
    return (cause == CAUSE_TRAP) ? tr_pc : br_pc;
  endfunction

endpackage

// File: rtl/branch_redirect_ctrl_fetch_drop_counter.sv
// Counts stale instruction-bus responses still to be discarded after a flush.
module fetch_drop_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_reg;

  // A load wins over a decrement; the counter saturates at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign cnt  = cnt_reg;
  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Sequences branch/trap redirects: flushes IF/ID, drops stale fetch responses, then
// holds a redirect request to the IFU; misaligned branch targets go to the trap unit.
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int CNT_W      = 2,
  parameter int WAIT_DRAIN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             ex_stall,
  input  logic             take_branch,
  input  logic [PC_W-1:0]  target_pc,
  input  logic             exc_addr_misaligned,
  input  logic             trap_req,
  input  logic [PC_W-1:0]  trap_pc,
  input  logic [CNT_W-1:0] if_outstanding_cnt,
  input  logic             if_rsp_valid,
  output logic             flush_if,
  output logic             flush_id,
  output logic             drop_rsp,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  input  logic             redirect_ready,
  output logic             branch_exc,
  output logic [PC_W-1:0]  branch_exc_tval,
  output logic             busy
);

  state_t           state_reg, state_next;
  logic             redirect_valid_reg;
  logic [PC_W-1:0]  redirect_pc_reg;
  logic             branch_exc_reg;
  logic [PC_W-1:0]  branch_exc_tval_reg;

  logic             br_ev, mis_ev, tr_ev, accept, exc_next;
  cause_t           cause;
  logic [CNT_W-1:0] load_val, drop_cnt;
  logic             drop_zero, dec;

  assign br_ev  = ex_valid & ~ex_stall & take_branch & ~exc_addr_misaligned;
  assign mis_ev = ex_valid & ~ex_stall & take_branch &  exc_addr_misaligned;
  assign tr_ev  = trap_req;
  assign accept = tr_ev | (br_ev & (state_reg == IDLE));
  assign cause  = tr_ev ? CAUSE_TRAP : CAUSE_BR;

  // The outstanding count already includes a response landing this cycle, which is
  // dropped directly and so must not be counted again.
  assign load_val = (if_outstanding_cnt == '0) ? '0
                  : if_outstanding_cnt - CNT_W'(if_rsp_valid);

  assign dec      = ~accept & if_rsp_valid & ~drop_zero;
  assign drop_rsp = accept ? if_rsp_valid : (if_rsp_valid & ~drop_zero);
  assign flush_if = accept;
  assign flush_id = accept;
  assign exc_next = mis_ev & ~tr_ev & (state_reg == IDLE);

  fetch_drop_counter #(.CNT_W(CNT_W)) u_drop_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (load_val),
    .dec      (dec),
    .cnt      (drop_cnt),
    .zero     (drop_zero)
  );

  always_comb begin
    state_next = state_reg;
    if (accept) begin
      state_next = ((WAIT_DRAIN != 0) && (load_val != '0)) ? DRAIN : REDIRECT;
    end else begin
      case (state_reg)
        IDLE: ;
        // Leave as soon as the last stale response is being dropped.
        DRAIN:    if (drop_zero || (dec && (drop_cnt == CNT_W'(1)))) state_next = REDIRECT;
        REDIRECT: if (redirect_valid_reg && redirect_ready) state_next = IDLE;
        default:  state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg           <= IDLE;
      redirect_valid_reg  <= 1'b0;
      redirect_pc_reg     <= '0;
      branch_exc_reg      <= 1'b0;
      branch_exc_tval_reg <= '0;
    end else begin
      state_reg          <= state_next;
      redirect_valid_reg <= (state_next == REDIRECT);
      branch_exc_reg     <= exc_next;
      if (accept) redirect_pc_reg <= sel_redirect_pc(cause, target_pc, trap_pc);
      if (exc_next) branch_exc_tval_reg <= target_pc;
    end
  end

  assign redirect_valid  = redirect_valid_reg;
  assign redirect_pc     = redirect_pc_reg;
  assign branch_exc      = branch_exc_reg;
  assign branch_exc_tval = branch_exc_tval_reg;
  assign busy            = (state_reg != IDLE);

endmodule
